// File: rtl/imm_gen_pkg.sv
// Shared decode definitions for the immediate-generation stage.
// Holds opcodes, CSR funct3 codes, immediate format codes and the pipeline entry type.
package imm_gen_pkg;

    localparam int MAX_XLEN = 64;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_FLOAD   = 7'b0000111;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_FSTORE  = 7'b0100111;
    localparam logic [6:0] OPC_AMO     = 7'b0101111;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_Z    = 3'd6
    } imm_type_t;

    // Fields are sized for the widest datapath; narrower builds use the low XLEN bits.
    typedef struct packed {
        logic [MAX_XLEN-1:0] imm;
        imm_type_t           imm_type;
        logic [MAX_XLEN-1:0] target;
        logic                illegal;
    } entry_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: instruction + PC to one pipeline entry.
// Everything is computed at 64 bits; the low XLEN bits equal the XLEN-wide result.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int FP_EN  = 1,
    parameter int CSR_EN = 1
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output entry_t          entry
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [63:0] pc64;
    logic [63:0] imm_i;
    logic [63:0] imm_s;
    logic [63:0] imm_b;
    logic [63:0] imm_u;
    logic [63:0] imm_j;
    logic [63:0] imm_z;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign pc64   = 64'(pc);

    assign imm_i = {{52{instr[31]}}, instr[31:20]};
    assign imm_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {{32{instr[31]}}, instr[31:12], 12'b0};
    assign imm_j = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_z = {59'b0, instr[19:15]};

    logic [63:0] imm64;
    imm_type_t   typ;
    logic        illegal;
    logic        use_target;

    always_comb begin
        imm64      = '0;
        typ        = IMM_NONE;
        illegal    = 1'b0;
        use_target = 1'b0;
        if (instr[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (opcode)
                OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
                    typ   = IMM_I;
                    imm64 = imm_i;
                end
                OPC_FLOAD: begin
                    if (FP_EN != 0) begin
                        typ   = IMM_I;
                        imm64 = imm_i;
                    end else begin
                        illegal = 1'b1;
                    end
                end
                OPC_STORE: begin
                    typ   = IMM_S;
                    imm64 = imm_s;
                end
                OPC_FSTORE: begin
                    if (FP_EN != 0) begin
                        typ   = IMM_S;
                        imm64 = imm_s;
                    end else begin
                        illegal = 1'b1;
                    end
                end
                OPC_BRANCH: begin
                    typ        = IMM_B;
                    imm64      = imm_b;
                    use_target = 1'b1;
                end
                OPC_LUI: begin
                    typ   = IMM_U;
                    imm64 = imm_u;
                end
                OPC_AUIPC: begin
                    typ        = IMM_U;
                    imm64      = imm_u;
                    use_target = 1'b1;
                end
                OPC_JAL: begin
                    typ        = IMM_J;
                    imm64      = imm_j;
                    use_target = 1'b1;
                end
                OPC_SYSTEM: begin
                    // Without CSR support SYSTEM is still a known opcode, just immediate-free.
                    if (CSR_EN != 0) begin
                        case (funct3)
                            F3_CSRRWI, F3_CSRRSI: begin
                                typ   = IMM_Z;
                                imm64 = imm_z;
                            end
                            F3_CSRRCI: begin
                                typ   = IMM_Z;
                                imm64 = ~imm_z;
                            end
                            default: ;
                        endcase
                    end
                end
                OPC_OP, OPC_MISCMEM, OPC_AMO: ;
                default: illegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        entry          = '0;
        entry.imm      = imm64;
        entry.imm_type = typ;
        entry.target   = use_target ? (pc64 + imm64) : 64'd0;
        entry.illegal  = illegal;
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate-generation stage with a 2-entry skid buffer.
// main_reg drives the outputs; skid_reg absorbs one extra entry under backpressure.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int FP_EN  = 1,
    parameter int CSR_EN = 1
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iValid,
    output logic            oReady,
    input  logic [31:0]     iInstr,
    input  logic [XLEN-1:0] iPC,
    output logic            oValid,
    input  logic            iReady,
    output logic [XLEN-1:0] oImm,
    output logic [2:0]      oImmType,
    output logic [XLEN-1:0] oTarget,
    output logic            oIllegal
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t state_reg;
    entry_t main_reg;
    entry_t skid_reg;
    entry_t dec_entry;
    logic   in_xfer;
    logic   out_xfer;

    imm_decode #(
        .XLEN   (XLEN),
        .FP_EN  (FP_EN),
        .CSR_EN (CSR_EN)
    ) u_decode (
        .instr (iInstr),
        .pc    (iPC),
        .entry (dec_entry)
    );

    assign oReady   = (state_reg != ST_TWO) && !iRST;
    assign oValid   = (state_reg != ST_EMPTY);
    assign in_xfer  = iValid && oReady;
    assign out_xfer = oValid && iReady;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_reg <= ST_EMPTY;
            main_reg  <= '0;
            skid_reg  <= '0;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_reg  <= dec_entry;
                        state_reg <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && !out_xfer) begin
                        skid_reg  <= dec_entry;
                        state_reg <= ST_TWO;
                    end else if (in_xfer && out_xfer) begin
                        main_reg  <= dec_entry;
                    end else if (out_xfer) begin
                        state_reg <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // Input is blocked here, so the only move is skid -> main.
                    if (out_xfer) begin
                        main_reg  <= skid_reg;
                        state_reg <= ST_ONE;
                    end
                end
                default: state_reg <= ST_EMPTY;
            endcase
        end
    end

    assign oImm     = main_reg.imm[XLEN-1:0];
    assign oImmType = main_reg.imm_type;
    assign oTarget  = main_reg.target[XLEN-1:0];
    assign oIllegal = main_reg.illegal;

    generate
        if (XLEN < MAX_XLEN) begin : g_narrow
            logic unused_hi;
            assign unused_hi = ^{main_reg.imm[MAX_XLEN-1:XLEN], main_reg.target[MAX_XLEN-1:XLEN]};
        end
    endgenerate

endmodule
